// File: rtl/tlc_pkg.sv
// tlc_pkg: shared definitions for the intersection sequencer.
//   - tlc_state_e : state encoding (MG..SY); 3'd7 is unused/illegal
//   - RYG_*       : lamp patterns, {R,Y,G}
//   - T_*_DEF     : default interval lengths in ticks
package tlc_pkg;

  typedef enum logic [2:0] {
    MG     = 3'd0,
    MG_EXT = 3'd1,
    MY     = 3'd2,
    WALK   = 3'd3,
    SG     = 3'd4,
    SG_EXT = 3'd5,
    SY     = 3'd6
  } tlc_state_e;

  localparam logic [2:0] RYG_RED = 3'b100;
  localparam logic [2:0] RYG_YEL = 3'b010;
  localparam logic [2:0] RYG_GRN = 3'b001;

  localparam int T_BASE_DEF = 6;
  localparam int T_EXT_DEF  = 3;
  localparam int T_YEL_DEF  = 2;
  localparam int CNT_W_DEF  = 4;

endpackage

// File: rtl/traffic_light_fsm_timer.sv
// interval_timer: loadable down-counter measuring a state's interval in ticks.
// Ports:
//   clk, Reset_n   clock, async active-low reset (count resets to RST_VAL)
//   Tick           one-cycle timing enable
//   load, load_val reload the count (takes priority over Tick)
//   Time_Left      remaining ticks in the current interval
//   expire         Tick on the last remaining tick of the interval
module interval_timer #(
  parameter int CNT_W   = 4,
  parameter int RST_VAL = 6
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             Tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] Time_Left,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)      cnt_d = load_val;
    else if (Tick) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) cnt_q <= CNT_W'(RST_VAL);
    else          cnt_q <= cnt_d;
  end

  assign Time_Left = cnt_q;
  assign expire    = Tick && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: intersection sequencer with sensor-driven green extension
// and a pedestrian walk phase inserted after main-yellow on request.
// Ports:
//   clk, Reset_n     clock, async active-low reset
//   Tick             one-cycle timing enable from the prescaler
//   Sensor           side-street vehicle present (sampled on green expiry)
//   WalkReq          latched pedestrian request (sampled on MY expiry)
//   WalkReg_Reset    one-cycle clear pulse on the first cycle of WALK
//   Main_RYG/Side_RYG  lamp outputs {R,Y,G}
//   Walk             walk lamp
//   State_Out        current state encoding (debug)
//   Time_Left        remaining ticks in the current state
module traffic_light_fsm
  import tlc_pkg::*;
#(
  parameter int T_BASE = T_BASE_DEF,
  parameter int T_EXT  = T_EXT_DEF,
  parameter int T_YEL  = T_YEL_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             Tick,
  input  logic             Sensor,
  input  logic             WalkReq,
  output logic             WalkReg_Reset,
  output logic [2:0]       Main_RYG,
  output logic [2:0]       Side_RYG,
  output logic             Walk,
  output logic [2:0]       State_Out,
  output logic [CNT_W-1:0] Time_Left
);

  tlc_state_e       state_q, state_d;
  logic             wrr_q, wrr_d;
  logic             expire;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;

  interval_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(T_BASE)
  ) u_timer (
    .clk      (clk),
    .Reset_n  (Reset_n),
    .Tick     (Tick),
    .load     (tmr_load),
    .load_val (tmr_val),
    .Time_Left(Time_Left),
    .expire   (expire)
  );

  // Next state: only an expiring tick moves the FSM; the illegal code
  // falls through to MG unconditionally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MG:      if (expire) state_d = Sensor  ? MG_EXT : MY;
      MG_EXT:  if (expire) state_d = MY;
      MY:      if (expire) state_d = WalkReq ? WALK   : SG;
      WALK:    if (expire) state_d = SG;
      SG:      if (expire) state_d = Sensor  ? SG_EXT : SY;
      SG_EXT:  if (expire) state_d = SY;
      SY:      if (expire) state_d = MG;
      default:             state_d = MG;
    endcase
  end

  // Every transition changes the state, so a change is exactly "entering".
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = CNT_W'(T_BASE);
    case (state_d)
      MG, SG:             tmr_val = CNT_W'(T_BASE);
      MG_EXT, SG_EXT, WALK: tmr_val = CNT_W'(T_EXT);
      MY, SY:             tmr_val = CNT_W'(T_YEL);
      default:            tmr_val = CNT_W'(T_BASE);
    endcase
  end

  assign wrr_d = (state_d == WALK) && (state_q != WALK);

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= MG;
      wrr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wrr_q   <= wrr_d;
    end
  end

  // Moore lamp decode; the illegal code shows all-red for its one cycle.
  always_comb begin
    Main_RYG = RYG_RED;
    Side_RYG = RYG_RED;
    Walk     = 1'b0;
    case (state_q)
      MG, MG_EXT: Main_RYG = RYG_GRN;
      MY:         Main_RYG = RYG_YEL;
      WALK:       Walk     = 1'b1;
      SG, SG_EXT: Side_RYG = RYG_GRN;
      SY:         Side_RYG = RYG_YEL;
      default:    ;
    endcase
  end

  assign WalkReg_Reset = wrr_q;
  assign State_Out     = state_q;

endmodule
